// File: rtl/lsu_pkg.sv
// Shared width codes, FSM state type and size helper for the sequential
// load/store unit (lsu_seq, lsu_align).
package lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;
  localparam logic [1:0] LSU_DBL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] size;
    case (funct3[1:0])
      LSU_BYTE: size = 4'd1;
      LSU_HALF: size = 4'd2;
      LSU_WORD: size = 4'd4;
      default:  size = 4'd8;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_seq_if.sv
// MEM-stage request/response and data-bus signals of lsu_seq, grouped with
// modports for the unit (master) and its surroundings (slave).
interface lsu_seq_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                mem_req_i;
  logic                mem_we_mem_i;
  logic [2:0]          mem_funct3;
  logic [ADDR_W-1:0]   mem_addr_i;
  logic [XLEN-1:0]     mem_dat_i;
  logic                mem_stall_o;
  logic                mem_done_o;
  logic [XLEN-1:0]     mem_dat_o;
  logic                mem_err_o;
  logic                mem_bus_err_o;
  logic                lsu_cyc_o;
  logic                lsu_stb_o;
  logic                lsu_we_o;
  logic [XLEN/8-1:0]   lsu_sel_o;
  logic [ADDR_W-1:0]   lsu_addr_o;
  logic [XLEN-1:0]     lsu_dat_o;
  logic [XLEN-1:0]     lsu_dat_i;
  logic                lsu_ack_i;
  logic                lsu_err_i;

  modport master (
    input  mem_req_i, mem_we_mem_i, mem_funct3, mem_addr_i, mem_dat_i,
    input  lsu_dat_i, lsu_ack_i, lsu_err_i,
    output mem_stall_o, mem_done_o, mem_dat_o, mem_err_o, mem_bus_err_o,
    output lsu_cyc_o, lsu_stb_o, lsu_we_o, lsu_sel_o, lsu_addr_o, lsu_dat_o
  );

  modport slave (
    output mem_req_i, mem_we_mem_i, mem_funct3, mem_addr_i, mem_dat_i,
    output lsu_dat_i, lsu_ack_i, lsu_err_i,
    input  mem_stall_o, mem_done_o, mem_dat_o, mem_err_o, mem_bus_err_o,
    input  lsu_cyc_o, lsu_stb_o, lsu_we_o, lsu_sel_o, lsu_addr_o, lsu_dat_o
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment, byte enables, replicated
// store data and sign/zero-extended load data.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic                       we,
  input  logic [$clog2(XLEN/8)-1:0]  addr_lo,
  input  logic [XLEN-1:0]            st_dat,
  input  logic [XLEN-1:0]            rd_dat,
  output logic                       misalign,
  output logic [XLEN/8-1:0]          sel,
  output logic [XLEN-1:0]            st_lanes,
  output logic [XLEN-1:0]            ld_ext
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int XW = $clog2(XLEN);

  logic [3:0]      size_s;
  logic            illegal_s;
  logic [NB-1:0]   base_s;
  logic [XLEN-1:0] shifted_s;
  logic [XW-1:0]   msb_s;
  logic            fill_s;

  assign size_s = size_bytes(funct3);

  // Illegal encodings are reported through the misalign flag.
  always_comb begin
    illegal_s = 1'b0;
    if ((funct3[1:0] == LSU_DBL) && (XLEN == 32)) begin
      illegal_s = 1'b1;
    end else if (we && funct3[2]) begin
      illegal_s = 1'b1;
    end else if ((XLEN == 32) && (funct3 == 3'b110)) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
    misalign = illegal_s || ((addr_lo & LW'(size_s - 4'd1)) != {LW{1'b0}});
  end

  // Contiguous mask of size bytes, moved up to the addressed lane.
  always_comb begin
    base_s = {NB{1'b0}};
    for (int i = 0; i < NB; i++) begin
      if (i < int'(size_s)) begin
        base_s[i] = 1'b1;
      end else begin
        base_s[i] = 1'b0;
      end
    end
    sel = base_s << addr_lo;
  end

  // Store data repeated across the bus at the access size.
  always_comb begin
    case (funct3[1:0])
      LSU_BYTE: st_lanes = {NB{st_dat[7:0]}};
      LSU_HALF: st_lanes = {(NB/2){st_dat[15:0]}};
      LSU_WORD: st_lanes = {(NB/4){st_dat[31:0]}};
      default:  st_lanes = st_dat;
    endcase
  end

  // Bring the addressed lane down to bit 0 and fill above its MSB.
  always_comb begin
    shifted_s = rd_dat >> {addr_lo, 3'b000};
    case (funct3[1:0])
      LSU_BYTE: msb_s = XW'(6'd7);
      LSU_HALF: msb_s = XW'(6'd15);
      LSU_WORD: msb_s = XW'(6'd31);
      default:  msb_s = XW'(XLEN - 1);
    endcase
    fill_s = ~funct3[2] & shifted_s[msb_s];
    ld_ext = {XLEN{1'b0}};
    for (int i = 0; i < XLEN; i++) begin
      if (i > int'(msb_s)) begin
        ld_ext[i] = fill_s;
      end else begin
        ld_ext[i] = shifted_s[i];
      end
    end
  end

endmodule

// File: rtl/lsu_seq.sv
// Sequential load/store unit: one handshaked bus cycle per MEM request.
// Optional bus watchdog: define LSU_TIMEOUT_EN.
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lsu_seq_if.master  bus
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  lsu_state_e      state_r, state_nx;
  logic            go_bus_s, done_nx, err_nx, bus_err_nx, load_upd_s, tmo_hit_s;
  logic            misalign_s;
  logic [NB-1:0]   sel_s;
  logic [XLEN-1:0] st_lanes_s, ld_ext_s;
  logic            cyc_r, we_r, done_r, err_r, bus_err_r;
  logic [NB-1:0]   sel_r;
  logic [ADDR_W-1:0] addr_r;
  logic [XLEN-1:0] dat_r, mem_dat_r;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (bus.mem_funct3),
    .we       (bus.mem_we_mem_i),
    .addr_lo  (bus.mem_addr_i[LW-1:0]),
    .st_dat   (bus.mem_dat_i),
    .rd_dat   (bus.lsu_dat_i),
    .misalign (misalign_s),
    .sel      (sel_s),
    .st_lanes (st_lanes_s),
    .ld_ext   (ld_ext_s)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
  logic [TW-1:0] tmo_cnt_r;

  // Cycles spent in BUS, restarted for every new bus cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || go_bus_s) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if (state_r == ST_BUS) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign tmo_hit_s = (state_r == ST_BUS) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and the one-cycle result flags; bus error beats ack.
  always_comb begin
    state_nx   = state_r;
    go_bus_s   = 1'b0;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    bus_err_nx = 1'b0;
    load_upd_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.mem_req_i && misalign_s) begin
          state_nx = ST_RESP;
          err_nx   = 1'b1;
        end else if (bus.mem_req_i) begin
          state_nx = ST_BUS;
          go_bus_s = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus.lsu_err_i) begin
          state_nx   = ST_RESP;
          bus_err_nx = 1'b1;
        end else if (bus.lsu_ack_i) begin
          state_nx   = ST_RESP;
          done_nx    = 1'b1;
          load_upd_s = ~we_r;
        end else if (tmo_hit_s) begin
          state_nx   = ST_RESP;
          bus_err_nx = 1'b1;
        end else begin
          state_nx = ST_BUS;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Registered bus master outputs, result pulses and load data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_r     <= 1'b0;
      we_r      <= 1'b0;
      sel_r     <= {NB{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      dat_r     <= {XLEN{1'b0}};
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      bus_err_r <= 1'b0;
      mem_dat_r <= {XLEN{1'b0}};
    end else begin
      done_r    <= done_nx;
      err_r     <= err_nx;
      bus_err_r <= bus_err_nx;
      cyc_r     <= (state_nx == ST_BUS);
      if (go_bus_s) begin
        we_r   <= bus.mem_we_mem_i;
        sel_r  <= sel_s;
        addr_r <= {bus.mem_addr_i[ADDR_W-1:LW], {LW{1'b0}}};
        dat_r  <= st_lanes_s;
      end else if (state_nx == ST_BUS) begin
        we_r <= we_r;
      end else begin
        we_r <= 1'b0;
      end
      if (load_upd_s) begin
        mem_dat_r <= ld_ext_s;
      end else begin
        mem_dat_r <= mem_dat_r;
      end
    end
  end

  assign bus.mem_stall_o   = bus.mem_req_i & (state_r != ST_RESP);
  assign bus.mem_done_o    = done_r;
  assign bus.mem_err_o     = err_r;
  assign bus.mem_bus_err_o = bus_err_r;
  assign bus.mem_dat_o     = mem_dat_r;
  assign bus.lsu_cyc_o     = cyc_r;
  assign bus.lsu_stb_o     = cyc_r;
  assign bus.lsu_we_o      = we_r;
  assign bus.lsu_sel_o     = sel_r;
  assign bus.lsu_addr_o    = addr_r;
  assign bus.lsu_dat_o     = dat_r;

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: a 32-bit and a 64-bit instance exercised
// one at a time against an arithmetic reference model.
module tb_lsu_seq;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        w64;
  logic        req, we, ack, err;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wdat, rdat;
  int          checks = 0;
  int          errors = 0;
  int          cycle_cnt = 0;
  logic [63:0] mdat_model [2];

  logic [5:0]  o_flags;  // {stall, done, err, bus_err, cyc, stb}
  logic        o_we;
  logic [7:0]  o_sel;
  logic [31:0] o_addr;
  logic [63:0] o_dat, o_mdat;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  lsu_seq_if #(.XLEN(32), .ADDR_W(32)) if32 ();
  lsu_seq_if #(.XLEN(64), .ADDR_W(32)) if64 ();

  assign if32.mem_req_i    = req & ~w64;
  assign if32.mem_we_mem_i = we;
  assign if32.mem_funct3   = f3;
  assign if32.mem_addr_i   = addr;
  assign if32.mem_dat_i    = wdat[31:0];
  assign if32.lsu_dat_i    = rdat[31:0];
  assign if32.lsu_ack_i    = ack & ~w64;
  assign if32.lsu_err_i    = err & ~w64;
  assign if64.mem_req_i    = req & w64;
  assign if64.mem_we_mem_i = we;
  assign if64.mem_funct3   = f3;
  assign if64.mem_addr_i   = addr;
  assign if64.mem_dat_i    = wdat;
  assign if64.lsu_dat_i    = rdat;
  assign if64.lsu_ack_i    = ack & w64;
  assign if64.lsu_err_i    = err & w64;

  lsu_seq #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) u_dut32 (
    .clk_i (clk), .rst_i (rst), .bus (if32));
  lsu_seq #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) u_dut64 (
    .clk_i (clk), .rst_i (rst), .bus (if64));

  assign o_flags = w64 ? {if64.mem_stall_o, if64.mem_done_o, if64.mem_err_o,
                          if64.mem_bus_err_o, if64.lsu_cyc_o, if64.lsu_stb_o}
                       : {if32.mem_stall_o, if32.mem_done_o, if32.mem_err_o,
                          if32.mem_bus_err_o, if32.lsu_cyc_o, if32.lsu_stb_o};
  assign o_we   = w64 ? if64.lsu_we_o   : if32.lsu_we_o;
  assign o_sel  = w64 ? if64.lsu_sel_o  : {4'd0, if32.lsu_sel_o};
  assign o_addr = w64 ? if64.lsu_addr_o : if32.lsu_addr_o;
  assign o_dat  = w64 ? if64.lsu_dat_o  : {32'd0, if32.lsu_dat_o};
  assign o_mdat = w64 ? if64.mem_dat_o  : {32'd0, if32.mem_dat_o};

  // One access from the IDLE cycle to the following IDLE cycle.
  // resp: 0 ack, 1 err, 2 ack+err, 3 silent slave.
  task automatic run_access(input logic wide, input logic st, input logic [2:0] fn,
                            input logic [31:0] a, input logic [63:0] wd,
                            input logic [63:0] rd, input int waits, input int resp);
    int nb, sz, off, nbus;
    logic bad;
    logic [7:0] esel;
    logic [31:0] eaddr;
    logic [63:0] edat, v, mask;
    nb  = wide ? 8 : 4;
    sz  = 1 << fn[1:0];
    off = int'(a % nb);
    bad = (fn[1:0] == 2'd3 && !wide) || (st && fn[2]) || (!wide && fn == 3'd6) || (a % sz != 0);
    esel  = 8'(((1 << sz) - 1) << off);
    eaddr = a - off;
    edat  = 64'd0;
    for (int i = 0; i < nb; i++) edat[8*i +: 8] = wd[8*(i % sz) +: 8];
    v = rd >> (8 * off);
    if (sz < 8) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = v & mask;
      if (!fn[2] && v[8*sz-1]) v = v | ~mask;
    end
    if (!wide) v = {32'd0, v[31:0]};

    w64 = wide; req = 1'b1; we = st; f3 = fn; addr = a; wdat = wd; rdat = rd;
    ack = 1'b0; err = 1'b0;
    @(negedge clk);
    checks++;
    if (o_flags !== 6'b100000) begin
      errors++; $display("FAIL req_cycle flags got %b want %b", o_flags, 6'b100000);
    end
    @(posedge clk); #1;
    if (bad) begin
      @(negedge clk);
      checks++;
      if (o_flags !== 6'b001000) begin
        errors++; $display("FAIL misalign_pulse flags got %b want %b (f3=%0d a=%h)", o_flags, 6'b001000, fn, a);
      end
      req = 1'b0;
      @(posedge clk); #1;
      return;
    end
    nbus = (resp == 3) ? TMO : waits + 1;
    for (int k = 0; k < nbus; k++) begin
      if (k == nbus - 1 && resp != 3) begin
        ack = (resp != 1);
        err = (resp != 0);
      end
      @(negedge clk);
      checks++;
      if ({o_flags, o_we} !== {6'b100011, st}) begin
        errors++; $display("FAIL bus_cycle%0d flags got %b want %b", k, {o_flags, o_we}, {6'b100011, st});
      end
      if (k == 0) begin
        checks++;
        if (o_sel !== esel || o_addr !== eaddr) begin
          errors++; $display("FAIL sel_addr got %h/%h want %h/%h", o_sel, o_addr, esel, eaddr);
        end
        if (st) begin
          checks++;
          if (o_dat !== edat) begin
            errors++; $display("FAIL store_lanes got %h want %h", o_dat, edat);
          end
        end
      end
      @(posedge clk); #1;
    end
    ack = 1'b0; err = 1'b0;
    if (resp == 0 && !st) mdat_model[wide] = v;
    @(negedge clk);
    checks++;
    if (o_flags !== {1'b0, resp == 0, 1'b0, resp != 0, 2'b00}) begin
      errors++; $display("FAIL resp_pulse flags got %b want %b", o_flags, {1'b0, resp == 0, 1'b0, resp != 0, 2'b00});
    end
    checks++;
    if (o_mdat !== mdat_model[wide]) begin
      errors++; $display("FAIL load_data got %h want %h (f3=%0d a=%h)", o_mdat, mdat_model[wide], fn, a);
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      w64 = w[0]; #1;
      checks++;
      if ({o_flags, o_we, o_sel, o_addr, o_dat, o_mdat} !== 175'd0) begin
        errors++; $display("FAIL reset_state w64=%0d got %b/%h/%h/%h/%h want zeros", w, o_flags, o_sel, o_addr, o_dat, o_mdat);
      end
    end
  endtask

  task automatic test_directed();
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 64'hDEADBEEF, 64'd0, 0, 0);
    run_access(1'b0, 1'b0, 3'b000, 32'h103, 64'd0, 64'h80123456, 3, 0);
    checks++;
    if (o_mdat !== 64'hFFFFFF80) begin
      errors++; $display("FAIL lb_value got %h want %h", o_mdat, 64'hFFFFFF80);
    end
    run_access(1'b0, 1'b0, 3'b100, 32'h103, 64'd0, 64'h80123456, 3, 0);
    checks++;
    if (o_mdat !== 64'h80) begin
      errors++; $display("FAIL lbu_value got %h want %h", o_mdat, 64'h80);
    end
    run_access(1'b0, 1'b0, 3'b001, 32'h101, 64'd0, 64'd0, 0, 0);
    run_access(1'b0, 1'b0, 3'b011, 32'h100, 64'd0, 64'd0, 0, 0);
    run_access(1'b0, 1'b1, 3'b110, 32'h100, 64'd0, 64'd0, 0, 0);
    run_access(1'b1, 1'b1, 3'b001, 32'h206, 64'h1234, 64'd0, 0, 0);
    run_access(1'b1, 1'b0, 3'b011, 32'h208, 64'd0, 64'h8877665544332211, 1, 0);
  endtask

  task automatic test_bus_err();
    run_access(1'b0, 1'b0, 3'b010, 32'h40, 64'd0, 64'h12345678, 2, 1);
    run_access(1'b1, 1'b0, 3'b011, 32'h48, 64'd0, 64'hFFFF0000FFFF0000, 0, 2);
  endtask

  task automatic test_reset_mid_bus();
    w64 = 1'b0; req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h80; rdat = 64'h5A5A5A5A;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_flags[1:0] !== 2'b11) begin
      errors++; $display("FAIL mid_reset_setup cyc/stb got %b want 11", o_flags[1:0]);
    end
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mdat_model[0] = 64'd0; mdat_model[1] = 64'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (o_flags !== 6'b000000 || o_mdat !== 64'd0) begin
        errors++; $display("FAIL mid_reset cycle%0d got %b/%h want 000000/0", k, o_flags, o_mdat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cycle_cnt;
    for (int i = 0; i < 3; i++)
      run_access(1'b1, 1'b0, 3'b010, 32'h300 + 32'(4 * i), 64'd0, {$urandom, $urandom}, 0, 0);
    checks++;
    if (cycle_cnt - t0 !== 9) begin
      errors++; $display("FAIL back_to_back cycles got %0d want 9", cycle_cnt - t0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int r;
      a = $urandom & 32'h0000_0FFF;
      if ($urandom_range(1, 0) == 1) a = a & ~32'd7;
      r = $urandom_range(7, 0);
      run_access(1'($urandom), 1'($urandom), 3'($urandom), a, {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(3, 0), (r < 6) ? 0 : r - 5);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b0, 1'b0, 3'b010, 32'h500, 64'd0, 64'd0, 0, 3);
    run_access(1'b1, 1'b1, 3'b011, 32'h508, 64'h0102030405060708, 64'd0, 0, 3);
  endtask
`else
  task automatic test_long_wait();
    run_access(1'b0, 1'b0, 3'b001, 32'h502, 64'd0, 64'h7FFF0000, 20, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; w64 = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'b000; addr = 32'd0;
    wdat = 64'd0; rdat = 64'd0; ack = 1'b0; err = 1'b0;
    mdat_model[0] = 64'd0; mdat_model[1] = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_bus_err();
    test_reset_mid_bus();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
